// File: rtl/ddr_sdr_pkg.sv
// ============================================================================
// Module      : ddr_sdr_pkg
// Description : Shared constants, phase encoding and sizing helper for the
//               DDR-to-SDR gearbox. DEF_CNT_W exists only with DDR_SDR_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr_sdr_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;
`ifdef DDR_SDR_STATS_EN
  localparam int DEF_CNT_W      = 16;
`endif

  typedef enum logic {
    PHASE_RISE_FIRST = 1'b0,
    PHASE_FALL_FIRST = 1'b1
  } phase_e;

  // One extra bit so a full FIFO is distinguishable from an empty one.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddr_to_sdr_gearbox_if.sv
// ============================================================================
// Module      : ddr_to_sdr_gearbox_if
// Description : DDR capture inputs and SDR word handshake of the gearbox.
//               ovf_count and CNT_W exist only with DDR_SDR_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ddr_to_sdr_gearbox_if
  import ddr_sdr_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
`ifdef DDR_SDR_STATS_EN
  ,
  parameter int CNT_W      = DEF_CNT_W
`endif
) ();

  localparam int LVL_W = level_w(FIFO_DEPTH);

  logic [DATA_W-1:0]   ddr_data;
  logic                in_en;
  logic                slip;
  logic [2*DATA_W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic [LVL_W-1:0]    level;
  logic                overflow;
  logic                ovf_clr;
`ifdef DDR_SDR_STATS_EN
  logic [CNT_W-1:0]    ovf_count;
`endif

  modport master (
    input  ddr_data, in_en, slip, out_ready, ovf_clr,
    output out_data, out_valid, level, overflow
`ifdef DDR_SDR_STATS_EN
    , output ovf_count
`endif
  );

  modport slave (
    output ddr_data, in_en, slip, out_ready, ovf_clr,
    input  out_data, out_valid, level, overflow
`ifdef DDR_SDR_STATS_EN
    , input ovf_count
`endif
  );

endinterface

`default_nettype wire

// File: rtl/ddr_sdr_fifo.sv
// ============================================================================
// Module      : ddr_sdr_fifo
// Description : Synchronous word FIFO with occupancy level; head data reads
//               as zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_sdr_fifo
  import ddr_sdr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  wire logic                      clk,
  input  wire logic                      rst_n,
  input  wire logic                      push,
  input  wire logic [WIDTH-1:0]          wr_data,
  input  wire logic                      pop,
  output logic      [WIDTH-1:0]          rd_data,
  output logic                           full,
  output logic                           empty,
  output logic      [level_w(DEPTH)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  // Storage needs no reset: the read port is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign full    = (r_level == LVL_W'(DEPTH));
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/ddr_to_sdr_gearbox.sv
// ============================================================================
// Module      : ddr_to_sdr_gearbox
// Description : Pairs rising/falling DDR samples into SDR words with phase
//               slip, FIFO buffering and overflow reporting.
//               Optional drop counter: DDR_SDR_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_to_sdr_gearbox
  import ddr_sdr_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
`ifdef DDR_SDR_STATS_EN
  ,
  parameter int CNT_W      = DEF_CNT_W
`endif
) (
  input wire logic              clk,
  input wire logic              rst_n,
  ddr_to_sdr_gearbox_if.master  bus
);

  localparam int LVL_W = level_w(FIFO_DEPTH);

  logic [DATA_W-1:0]   r_rise_q;
  logic [DATA_W-1:0]   r_fall_q;
  logic [DATA_W-1:0]   r_fall_d;
  logic                r_en_q;
  logic                r_en_d;
  phase_e              r_phase;
  logic                r_discard;
  logic                r_overflow;

  logic [2*DATA_W-1:0] w_cand_word;
  logic                w_cand_valid;
  logic                w_push_req;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic                w_full;
  logic                w_empty;
  logic [2*DATA_W-1:0] w_rd_data;
  logic [LVL_W-1:0]    w_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise_q <= '0;
      r_en_q   <= 1'b0;
      r_fall_d <= '0;
      r_en_d   <= 1'b0;
    end else begin
      r_rise_q <= bus.ddr_data;
      r_en_q   <= bus.in_en;
      r_fall_d <= r_fall_q;
      r_en_d   <= r_en_q;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fall_q <= '0;
    end else begin
      r_fall_q <= bus.ddr_data;
    end
  end

  // Fall-first pairing takes the previous cycle's falling sample as the older half.
  always_comb begin
    w_cand_word  = {r_fall_q, r_rise_q};
    w_cand_valid = r_en_q;
    if (r_phase == PHASE_FALL_FIRST) begin
      w_cand_word  = {r_rise_q, r_fall_d};
      w_cand_valid = r_en_q & r_en_d;
    end
  end

  assign w_push_req = w_cand_valid & ~r_discard;
  assign w_pop      = ~w_empty & bus.out_ready;
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_push     = w_push_req & ~w_drop;

  // A slip arms a single discard; repeated slips only re-arm it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= PHASE_RISE_FIRST;
      r_discard <= 1'b0;
    end else begin
      if (bus.slip) begin
        r_phase   <= (r_phase == PHASE_RISE_FIRST) ? PHASE_FALL_FIRST : PHASE_RISE_FIRST;
        r_discard <= 1'b1;
      end else if (w_cand_valid) begin
        r_discard <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef DDR_SDR_STATS_EN
  logic [CNT_W-1:0] r_ovf_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_count <= '0;
    end else if (w_drop) begin
      if (bus.ovf_clr)       r_ovf_count <= CNT_W'(1);
      else if (!(&r_ovf_count)) r_ovf_count <= r_ovf_count + 1'b1;
    end else if (bus.ovf_clr) begin
      r_ovf_count <= '0;
    end
  end

  assign bus.ovf_count = r_ovf_count;
`endif

  ddr_sdr_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (w_push),
    .wr_data (w_cand_word),
    .pop     (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .level   (w_level)
  );

  assign bus.out_data  = w_rd_data;
  assign bus.out_valid = ~w_empty;
  assign bus.level     = w_level;
  assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: doc/ddr_to_sdr_gearbox.md
# ddr_to_sdr_gearbox

Parametrised DDR-to-SDR deserialiser and buffer. It captures a DATA_W-bit DDR bus on both clock edges and pairs each rising-edge sample with a falling-edge sample into one 2*DATA_W-bit SDR word. Words pass through a small FIFO with a valid/ready handshake. It sits between the DDR pad-capture logic and the single-edge datapath, and adds phase slip, backpressure and overflow reporting.

## Interface
- DATA_W, 8: DDR bus width in bits.
- FIFO_DEPTH, 4: word FIFO depth; a power of two and at least 2.
- CNT_W, 16: overflow counter width (only with DDR_SDR_STATS_EN).
- clk  in  1  single clock; DDR data is sampled on posedge and negedge.
- rst_n  in  1  asynchronous, active-low reset.
- ddr_data  in  DATA_W  DDR input bus.
- in_en  in  1  sampled at posedge together with the rising sample; marks that beat as valid.
- slip  in  1  one-cycle pulse (posedge) that toggles the pairing phase.
- out_data  out  2*DATA_W  FIFO head; the first-in-time sample is in the low half.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head word.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky flag; set when a word is dropped.
- ovf_clr  in  1  clears overflow (and ovf_count).
- ovf_count  out  CNT_W  saturating count of dropped words (DDR_SDR_STATS_EN only).

## Operation
- Capture registers:
  - rise_q, en_q: posedge capture of ddr_data and in_en.
  - fall_q: negedge capture of ddr_data.
  - fall_d: fall_q delayed by one posedge.
  - en_d: en_q delayed by one posedge.
- Phase 0 (reset): candidate = {fall_q, rise_q}; candidate is valid when en_q=1.
- Phase 1: candidate = {rise_q, fall_d}; candidate is valid when en_q=1 and en_d=1.
- slip=1 at a posedge toggles phase at that edge. The first valid candidate after a toggle is discarded and does not count as overflow. Further slip pulses during a pending discard toggle phase again; only one candidate is discarded.
- Push: a valid, non-discarded candidate is written at posedge.
- Pop: out_valid=1 and out_ready=1 at posedge.
- Full with push and no pop: the word is dropped and overflow is set. With DDR_SDR_STATS_EN, ovf_count increments and saturates at all-ones.
- Full with push and pop in the same cycle: both happen and level is unchanged.
- Empty with push: there is no bypass; out_valid rises after the write edge.
- ovf_clr=1 clears overflow and ovf_count. If a drop occurs in the same cycle, the drop wins: overflow=1 and ovf_count=1.
- out_data is driven 0 whenever out_valid=0.
- Pointers wrap modulo FIFO_DEPTH. level distinguishes full (FIFO_DEPTH) from empty (0).

## Timing
- Reset values: out_valid=0, out_data=0, level=0, overflow=0, ovf_count=0, phase=0.
- Reset also clears all capture registers, pointers and the discard-pending flag.
- Assertion of rst_n mid-operation discards FIFO contents immediately and asynchronously. Capture resumes at the first posedge after release.
- Latency, phase 0:
  - Rising sample is captured at posedge k with in_en=1.
  - Falling sample is captured at negedge k.
  - The word is written at posedge k+1, so out_valid=1 after posedge k+1 (FIFO empty).
- Latency in phase 1 is the same, measured from the rising sample.
- Throughput is one word per cycle, sustained when out_ready=1.

## Configuration
- DDR_SDR_STATS_EN defined: ovf_count port and its saturating counter are present.
- DDR_SDR_STATS_EN undefined:
  - ovf_count is absent.
  - overflow and ovf_clr behave identically.
  - No counter logic is built.

## Structure
- Package ddr_sdr_pkg holds:
  - default DATA_W and FIFO_DEPTH constants;
  - phase encoding (PHASE_RISE_FIRST=0, PHASE_FALL_FIRST=1);
  - a function for level width.
- Sub-module ddr_sdr_fifo holds the synchronous FIFO (push, pop, full, empty, level, head data).
- Capture, phase and overflow logic stay in the top module.

## Test plan
- Reset then pairs: in_en=1; rising/falling pairs A1/A2, B1/B2 -> words 0xA2A1 then 0xB2B1.
  - out_valid rises after posedge k+1.
  - Both words are popped with out_ready=1.
- Slip: pulse slip mid-stream (stream R=0x10,F=0x11,R=0x20,F=0x21,...) -> one candidate discarded.
  - Following words are {R(n), F(n-1)}, e.g. 0x2011, 0x3021.
  - overflow stays 0.
- Backpressure: out_ready=0, push 6 words with FIFO_DEPTH=4 -> level=4 and overflow=1.
  - ovf_count=2 with DDR_SDR_STATS_EN.
  - The first 4 words are preserved in order.
- Full with pop: level=4, push and pop in the same cycle -> level stays 4 and overflow is not set.
- ovf_clr coincident with a drop -> overflow=1 and ovf_count=1.
- Mid-stream reset: level=3, assert rst_n=0 -> out_valid=0, level=0, out_data=0 immediately; phase returns to 0.
